// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared state encoding and March C- element table for the SRAM BIST.
package sram_bist_pkg;
   typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;
   localparam int FAIL_CNT_W = 8;
   // Element tables are indexed by element number (M0 = bit 0).
   localparam logic [7:0] EL_DOWN = 8'b0001_1000;
   localparam logic [7:0] EL_TWO  = 8'b0001_1110;
   localparam logic [7:0] EL_RPOL = 8'b0001_0100;
   localparam logic [7:0] EL_WPOL = 8'b0000_1010;
endpackage

// File: rtl/sram_bist_addr_gen.sv
// sram_bist_addr_gen: loadable up/down address counter with terminal-count flag.
module sram_bist_addr_gen #(
   parameter int ADDR_WIDTH = 4,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
)(
   input  logic                  clk0,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic                  down,
   input  logic [ADDR_WIDTH-1:0] load_val,
   output logic [ADDR_WIDTH-1:0] cnt,
   output logic [ADDR_WIDTH-1:0] nxt,
   output logic                  tc
);
   always_comb nxt = load ? load_val : step ? (down ? cnt - 1'b1 : cnt + 1'b1) : cnt;
   assign tc = down ? (cnt == '0) : (cnt == ADDR_WIDTH'(RAM_DEPTH - 1));
   always_ff @(posedge clk0 or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= nxt;
endmodule

// File: rtl/sram_bist_march.sv
// sram_bist_march: March C- BIST initiator for one OpenRAM 1RW port with miscompare reporting.
module sram_bist_march import sram_bist_pkg::*; #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
)(
   input  logic                  clk0,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [FAIL_CNT_W-1:0] fail_count,
   output logic                  csb0,
   output logic                  web0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0
);
   state_t state, state_n;
   logic phase, phase_n, ld, step, tc, go, issue, rd, csb_n, web_n;
   logic [2:0] e, e_n;
   logic [ADDR_WIDTH-1:0] ld_val, nxt, s1_addr, s2_addr;
   logic [DATA_WIDTH-1:0] din_n, s1_exp, s2_exp;
   logic s1_v, s2_v;

   assign e  = 3'(state - M0);
   assign go = (state == IDLE || state == DONE) && start;

   sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_addr (
      .clk0(clk0), .rst_n(rst_n), .load(ld), .step(step), .down(EL_DOWN[e]),
      .load_val(ld_val), .cnt(addr0), .nxt(nxt), .tc(tc)
   );

   // state/phase/counter always describe the op that will sit on the port after this edge
   always_comb begin
      state_n = state;
      phase_n = phase;
      ld      = 1'b0;
      ld_val  = '0;
      step    = 1'b0;
      if (state == IDLE || state == DONE) begin
         if (start) begin
            state_n = M0;
            phase_n = 1'b0;
            ld      = 1'b1;
         end
      end else if (state == DRAIN) begin
         state_n = DONE;
      end else if (EL_TWO[e] && !phase) begin
         phase_n = 1'b1;
      end else if (!tc) begin
         phase_n = 1'b0;
         step    = 1'b1;
      end else begin
         phase_n = 1'b0;
         if (state == M5) begin
            state_n = DRAIN;
         end else begin
            state_n = state_t'(state + 4'd1);
            ld      = 1'b1;
            ld_val  = {ADDR_WIDTH{EL_DOWN[e + 3'd1]}};
         end
      end
      issue = state_n != IDLE && state_n != DRAIN && state_n != DONE;
      e_n   = 3'(state_n - M0);
      rd    = issue && (state_n == M5 || (EL_TWO[e_n] && !phase_n));
      csb_n = !issue;
      web_n = !(issue && !rd);
      din_n = (issue && !rd) ? {DATA_WIDTH{EL_WPOL[e_n]}} : din0;
   end

   always_ff @(posedge clk0 or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         phase <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
      end

   always_ff @(posedge clk0 or negedge rst_n)
      if (!rst_n) begin
         csb0       <= 1'b1;
         web0       <= 1'b1;
         din0       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_count <= '0;
         s1_v       <= 1'b0;
         s1_exp     <= '0;
         s1_addr    <= '0;
         s2_v       <= 1'b0;
         s2_exp     <= '0;
         s2_addr    <= '0;
      end else begin
         csb0    <= csb_n;
         web0    <= web_n;
         din0    <= din_n;
         busy    <= state_n != IDLE && state_n != DONE;
         done    <= state_n == DONE;
         s1_v    <= rd;
         s1_exp  <= {DATA_WIDTH{EL_RPOL[e_n]}};
         s1_addr <= nxt;
         s2_v    <= s1_v;
         s2_exp  <= s1_exp;
         s2_addr <= s1_addr;
         if (go) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
         end else if (s2_v && (dout0 !== s2_exp)) begin
            fail <= 1'b1;
            if (!fail) fail_addr <= s2_addr;
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
         end
      end
endmodule

// File: tb/tb_sram_bist_march.sv
// tb_sram_bist_march: fault-injection vectors and corner sequences for the March C- BIST.
module tb_sram_bist_march;
   logic clk0 = 1'b0, rst_n, start, start8;
   logic busy, done, fail, csb0, web0;
   logic [3:0] fail_addr, addr0;
   logic [7:0] fail_count;
   logic [1:0] din0, dout0 = '0;
   logic busy8, done8, fail8, csb8, web8;
   logic [2:0] fail_addr8, addr8;
   logic [7:0] fail_count8, din8, dout8 = '0;
   logic [1:0] mem [16];
   logic [7:0] mem8 [8];
   int nchk = 0, nerr = 0;

   typedef struct {
      logic [3:0] fa0; logic [1:0] m0a, m1a;
      logic [3:0] fa1; logic [1:0] m0b, m1b;
      logic efail; logic [3:0] eaddr; logic [7:0] ecnt;
   } vec_t;
   vec_t tbl [6];
   vec_t cur;

   always #5 clk0 = ~clk0;

   sram_bist_march dut (
      .clk0(clk0), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_count(fail_count), .csb0(csb0), .web0(web0),
      .addr0(addr0), .din0(din0), .dout0(dout0)
   );
   sram_bist_march #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut8 (
      .clk0(clk0), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8), .fail(fail8),
      .fail_addr(fail_addr8), .fail_count(fail_count8), .csb0(csb8), .web0(web8),
      .addr0(addr8), .din0(din8), .dout0(dout8)
   );

   // m0 masks force bits to 0, m1 masks force bits to 1 on the read path
   always @(posedge clk0)
      if (!csb0) begin
         if (!web0) mem[addr0] <= din0;
         else dout0 <= (mem[addr0] & ~((addr0 == cur.fa0 ? cur.m0a : 2'b0) | (addr0 == cur.fa1 ? cur.m0b : 2'b0)))
                       | (addr0 == cur.fa0 ? cur.m1a : 2'b0) | (addr0 == cur.fa1 ? cur.m1b : 2'b0);
      end

   always @(posedge clk0)
      if (!csb8) begin
         if (!web8) mem8[addr8] <= din8;
         else dout8 <= (addr8 == 3'd2) ? 8'hA5 : mem8[addr8];
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input bit hold, input string tag);
      int n, ncs, nrd;
      cur = v;
      @(negedge clk0); start = 1'b1;
      @(posedge clk0); #1;
      if (!hold) start = 1'b0;
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_done0"}, done, 0);
      chk({tag, "_fail0"}, fail, 0);
      chk({tag, "_cnt0"}, fail_count, 0);
      chk({tag, "_csb0"}, csb0, 0);
      chk({tag, "_web0"}, web0, 0);
      chk({tag, "_addr0"}, addr0, 0);
      ncs = 1; nrd = 0; n = 0;
      while (!done && n < 400) begin
         @(posedge clk0); #1;
         n++;
         if (!csb0) begin
            ncs++;
            if (web0) nrd++;
         end
      end
      chk({tag, "_done_edge"}, n, 161);
      chk({tag, "_ops"}, ncs, 160);
      chk({tag, "_reads"}, nrd, 80);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_fail"}, fail, v.efail);
      chk({tag, "_fail_addr"}, fail_addr, v.eaddr);
      chk({tag, "_fail_count"}, fail_count, v.ecnt);
   endtask

   initial begin
      int n;
      tbl[0] = '{4'd0,  2'b00, 2'b00, 4'd0, 2'b00, 2'b00, 1'b0, 4'd0,  8'd0};
      tbl[1] = '{4'd5,  2'b01, 2'b00, 4'd0, 2'b00, 2'b00, 1'b1, 4'd5,  8'd2};
      tbl[2] = '{4'd15, 2'b00, 2'b10, 4'd0, 2'b00, 2'b00, 1'b1, 4'd15, 8'd3};
      tbl[3] = '{4'd0,  2'b00, 2'b11, 4'd0, 2'b00, 2'b00, 1'b1, 4'd0,  8'd3};
      tbl[4] = '{4'd3,  2'b10, 2'b01, 4'd0, 2'b00, 2'b00, 1'b1, 4'd3,  8'd5};
      tbl[5] = '{4'd12, 2'b00, 2'b01, 4'd4, 2'b10, 2'b00, 1'b1, 4'd12, 8'd5};
      cur = tbl[0];
      rst_n = 1'b1; start = 1'b0; start8 = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk0);
      #1;
      chk("rst_csb0", csb0, 1);
      chk("rst_web0", web0, 1);
      chk("rst_addr0", addr0, 0);
      chk("rst_din0", din0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_fail_count", fail_count, 0);
      @(negedge clk0); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) run(tbl[i], 1'b0, $sformatf("v%0d", i));
      run(tbl[1], 1'b1, "hold1");
      run(tbl[1], 1'b1, "hold2");
      start = 1'b0;
      cur = tbl[0];
      @(negedge clk0); start = 1'b1;
      @(posedge clk0); #1 start = 1'b0;
      repeat (50) @(posedge clk0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_csb0", csb0, 1);
      chk("midrst_web0", web0, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_addr0", addr0, 0);
      @(negedge clk0); rst_n = 1'b1;
      run(tbl[0], 1'b0, "after_rst");
      @(negedge clk0); start8 = 1'b1;
      @(posedge clk0); #1 start8 = 1'b0;
      chk("w8_busy0", busy8, 1);
      n = 0;
      while (!done8 && n < 200) begin
         @(posedge clk0); #1;
         n++;
      end
      chk("w8_done_edge", n, 81);
      chk("w8_fail", fail8, 1);
      chk("w8_fail_addr", fail_addr8, 2);
      chk("w8_fail_count", fail_count8, 5);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
